// File: rtl/egress_rr_merger_pkg.sv
// Shared constants and types for the egress round-robin merger.
package egress_rr_merger_pkg;

    // FIFO word width and per-channel delivered-word counter width
    localparam int DATA_WIDTH = 10;
    localparam int CNT_WIDTH  = 5;

    // Destination field inside a FIFO word
    localparam int DEST_HI = 9;
    localparam int DEST_LO = 8;

    // Merger FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    // Channel index to one-hot pop vector
    function automatic logic [3:0] onehot4(input logic [1:0] ch);
        return 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/egress_rr_merger_rr_arbiter4.sv
// Four-way round-robin arbiter, purely combinational.
// The search starts at last_grant+1 and wraps, so the last winner has lowest priority.
module rr_arbiter4 (
    input  logic [3:0] req_i,
    input  logic [1:0] last_grant_i,
    output logic [1:0] grant_o,
    output logic       any_req_o
);

    // first requesting channel after last_grant, last_grant itself checked last
    always_comb begin
        logic [1:0] cand;
        grant_o   = last_grant_i;
        any_req_o = 1'b0;
        cand      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant_i + 2'(i);
            if (!any_req_o && req_i[cand]) begin
                any_req_o = 1'b1;
                grant_o   = cand;
            end
        end
    end

endmodule

// File: rtl/egress_rr_merger.sv
// Egress round-robin merger: drains FIFOs 4..7 through one-cycle pop strobes and
// presents each word on a valid/ready stream tagged with its source channel.
// Words whose destination field disagrees with the source channel set a sticky flag.
// Optional feature macro EGRESS_CNT_EN: per-channel delivered-word counters with
// idx/req readout; without it the readout outputs are tied low.
module egress_rr_merger
    import egress_rr_merger_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty4,
    input  logic                  empty5,
    input  logic                  empty6,
    input  logic                  empty7,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out4,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out5,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out6,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out7,
    output logic                  pop4,
    output logic                  pop5,
    output logic                  pop6,
    output logic                  pop7,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_src,
    output logic                  err_dest,
    output logic                  IDLE,
    input  logic [1:0]            idx,
    input  logic                  req,
    output logic [CNT_WIDTH-1:0]  contador_out,
    output logic                  valid_contador
);

    state_e                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic [1:0]              last_grant_q;
    logic [3:0]              pop_q, pop_d;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [1:0]              out_src_q;
    logic                    err_q;

    logic [3:0]              fifo_req;
    logic [1:0]              arb_last;
    logic [1:0]              arb_grant;
    logic                    arb_any;
    logic                    load;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign fifo_req = ~{empty7, empty6, empty5, empty4};

    // While holding, the word being transferred is the most recent winner even
    // though last_grant only updates on that same edge.
    assign arb_last = (state_q == ST_HOLD) ? grant_q : last_grant_q;

    rr_arbiter4 u_arb (
        .req_i        (fifo_req),
        .last_grant_i (arb_last),
        .grant_o      (arb_grant),
        .any_req_o    (arb_any)
    );

    // read-data mux for the granted FIFO
    always_comb begin
        rd_word = FIFO_data_out4;
        case (grant_q)
            2'd0: rd_word = FIFO_data_out4;
            2'd1: rd_word = FIFO_data_out5;
            2'd2: rd_word = FIFO_data_out6;
            2'd3: rd_word = FIFO_data_out7;
            default: rd_word = FIFO_data_out4;
        endcase
    end

    // FSM next state, grant selection and pop strobe
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        pop_d   = '0;
        load    = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d = ST_READ;
                    grant_d = arb_grant;
                    pop_d   = onehot4(arb_grant);
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                load    = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    xfer = 1'b1;
                    if (arb_any) begin
                        state_d = ST_READ;
                        grant_d = arb_grant;
                        pop_d   = onehot4(arb_grant);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, grant and pop registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            pop_q        <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pop_q   <= pop_d;
            if (xfer) last_grant_q <= grant_q;
        end
    end

    // egress output register and sticky destination check
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            err_q       <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rd_word;
            out_src_q   <= grant_q;
            if (rd_word[DEST_HI:DEST_LO] != grant_q) err_q <= 1'b1;
        end else if (xfer) begin
            out_valid_q <= 1'b0;
        end
    end

    assign {pop7, pop6, pop5, pop4} = pop_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign err_dest  = err_q;
    assign IDLE      = (state_q == ST_IDLE) && (fifo_req == 4'b0000);

`ifdef EGRESS_CNT_EN
    logic [3:0][CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0]      cnt_rd_q;
    logic                      cnt_vld_q;

    // per-channel delivered-word counters, wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else if (xfer) cnt_q[grant_q] <= cnt_q[grant_q] + CNT_WIDTH'(1);
    end

    // readout samples the pre-edge count, so a same-edge increment is not seen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_rd_q  <= '0;
            cnt_vld_q <= 1'b0;
        end else begin
            cnt_vld_q <= req;
            if (req) cnt_rd_q <= cnt_q[idx];
        end
    end

    assign contador_out   = cnt_rd_q;
    assign valid_contador = cnt_vld_q;
`else
    logic unused_cnt_in;
    assign unused_cnt_in  = ^{idx, req};
    assign contador_out   = '0;
    assign valid_contador = 1'b0;
`endif

endmodule

// File: tb/tb_egress_rr_merger.sv
// Directed bench for egress_rr_merger with a behavioural model of the four FIFOs.
module tb_egress_rr_merger;

    logic       clk = 1'b0;
    logic       reset;
    logic       empty4, empty5, empty6, empty7;
    logic [9:0] dout [4];
    logic       pop4, pop5, pop6, pop7;
    logic       out_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic [1:0] out_src;
    logic       err_dest;
    logic       IDLE;
    logic [1:0] idx;
    logic       req;
    logic [4:0] contador_out;
    logic       valid_contador;

    int checks = 0;
    int errors = 0;

    // FIFO model storage: written by the stimulus, drained by pops
    logic [9:0] mem [4][256];
    int         wr [4];
    int         rd [4];
    logic [3:0] popv;

    assign popv   = {pop7, pop6, pop5, pop4};
    assign empty4 = (wr[0] == rd[0]);
    assign empty5 = (wr[1] == rd[1]);
    assign empty6 = (wr[2] == rd[2]);
    assign empty7 = (wr[3] == rd[3]);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (popv[k] && (wr[k] != rd[k])) begin
                dout[k] <= mem[k][rd[k] % 256];
                rd[k]   <= rd[k] + 1;
            end
        end
    end

    egress_rr_merger dut (
        .clk            (clk),
        .reset          (reset),
        .empty4         (empty4),
        .empty5         (empty5),
        .empty6         (empty6),
        .empty7         (empty7),
        .FIFO_data_out4 (dout[0]),
        .FIFO_data_out5 (dout[1]),
        .FIFO_data_out6 (dout[2]),
        .FIFO_data_out7 (dout[3]),
        .pop4           (pop4),
        .pop5           (pop5),
        .pop6           (pop6),
        .pop7           (pop7),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_src        (out_src),
        .err_dest       (err_dest),
        .IDLE           (IDLE),
        .idx            (idx),
        .req            (req),
        .contador_out   (contador_out),
        .valid_contador (valid_contador)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input int ch, input logic [9:0] w);
        mem[ch][wr[ch] % 256] = w;
        wr[ch] = wr[ch] + 1;
    endtask

    task automatic wait_valid(input int maxc, input string tag);
        int n = 0;
        while (!out_valid && n < maxc) begin
            step();
            n++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while (!IDLE && n < maxc) begin
            step();
            n++;
        end
        chk(tag, {31'd0, IDLE}, 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        logic [15:0] pop_seq;
        logic [15:0] src_seq;
        logic [9:0]  held;
        int          tcount;
        int          exp_w;
        int          ch;
        logic        bad;

        reset     = 1'b0;
        out_ready = 1'b1;
        idx       = 2'd0;
        req       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr[k]   = 0;
            dout[k] = 10'd0;
        end

        // reset with all FIFOs empty
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {22'd0, out_data}, 32'd0);
        chk("rst_src", {30'd0, out_src}, 32'd0);
        chk("rst_pops", {28'd0, popv}, 32'd0);
        chk("rst_err", {31'd0, err_dest}, 32'd0);
        chk("rst_idle", {31'd0, IDLE}, 32'd1);
        chk("rst_cnt", {27'd0, contador_out}, 32'd0);
        chk("rst_cnt_vld", {31'd0, valid_contador}, 32'd0);
        @(negedge clk);
        step();
        reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (popv != 4'b0) bad = 1'b1;
        end
        chk("idle_no_pop", {31'd0, bad}, 32'd0);
        chk("idle_flag", {31'd0, IDLE}, 32'd1);

        // single word from FIFO 5
        push(1, 10'h155);
        step();
        chk("w1_pop5_on", {28'd0, popv}, 32'h2);
        chk("w1_valid_e1", {31'd0, out_valid}, 32'd0);
        step();
        chk("w1_pop5_off", {28'd0, popv}, 32'h0);
        chk("w1_valid_e2", {31'd0, out_valid}, 32'd0);
        step();
        chk("w1_valid", {31'd0, out_valid}, 32'd1);
        chk("w1_data", {22'd0, out_data}, 32'h155);
        chk("w1_src", {30'd0, out_src}, 32'd1);
        chk("w1_err", {31'd0, err_dest}, 32'd0);
        step();
        chk("w1_done_valid", {31'd0, out_valid}, 32'd0);
        chk("w1_done_idle", {31'd0, IDLE}, 32'd1);

        // two words in every FIFO, round robin from FIFO 4 after reset
        pulse_reset();
        for (int k = 0; k < 4; k++) push(k, 10'((k << 8) | (8'hA0 + k)));
        for (int k = 0; k < 4; k++) push(k, 10'((k << 8) | (8'hB0 + k)));
        pop_seq = '0;
        src_seq = '0;
        tcount  = 0;
        bad     = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (popv != 4'b0) begin
                ch = 0;
                for (int k = 0; k < 4; k++) if (popv[k]) ch = k;
                if ($countones(popv) != 1) bad = 1'b1;
                pop_seq = {pop_seq[13:0], 2'(ch)};
            end
            if (out_valid && out_ready) begin
                exp_w = ((tcount % 4) << 8) | ((tcount < 4 ? 8'hA0 : 8'hB0) + (tcount % 4));
                chk($sformatf("rr_data%0d", tcount), {22'd0, out_data}, 32'(exp_w));
                src_seq = {src_seq[13:0], out_src};
                tcount++;
            end
        end
        chk("rr_pop_onehot", {31'd0, bad}, 32'd0);
        chk("rr_pop_order", {16'd0, pop_seq}, 32'h1B1B);
        chk("rr_src_order", {16'd0, src_seq}, 32'h1B1B);
        chk("rr_xfers_24cyc", 32'(tcount), 32'd8);
        step();
        chk("rr_idle_after", {31'd0, IDLE}, 32'd1);
        chk("rr_err", {31'd0, err_dest}, 32'd0);

        // destination mismatch from FIFO 4, then five clean words
        push(0, 10'h300);
        push(1, 10'h111);
        push(2, 10'h222);
        push(3, 10'h333);
        push(1, 10'h144);
        push(2, 10'h255);
        wait_valid(10, "bad_wait_valid");
        chk("bad_data", {22'd0, out_data}, 32'h300);
        chk("bad_src", {30'd0, out_src}, 32'd0);
        chk("bad_err_set", {31'd0, err_dest}, 32'd1);
        wait_idle(40, "bad_wait_idle");
        chk("bad_err_sticky", {31'd0, err_dest}, 32'd1);
        chk("bad_fifos_drained", 32'(rd[1] + rd[2] + rd[3] - wr[1] - wr[2] - wr[3]), 32'd0);

        // output stall with a competing FIFO non-empty
        out_ready = 1'b0;
        push(2, 10'h2AA);
        wait_valid(10, "stall_wait_valid");
        chk("stall_data0", {22'd0, out_data}, 32'h2AA);
        held = out_data;
        push(3, 10'h3CC);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (!out_valid || out_data !== held || popv != 4'b0) bad = 1'b1;
        end
        chk("stall_stable_nopop", {31'd0, bad}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("stall_xfer_valid", {31'd0, out_valid}, 32'd0);
        chk("stall_next_pop7", {28'd0, popv}, 32'h8);
        wait_valid(10, "stall_next_valid");
        chk("stall_next_data", {22'd0, out_data}, 32'h3CC);
        chk("stall_next_src", {30'd0, out_src}, 32'd3);
        wait_idle(10, "stall_wait_idle");

`ifdef EGRESS_CNT_EN
        // 33 words through FIFO 6 wrap its 5-bit counter to 1
        pulse_reset();
        for (int i = 0; i < 33; i++) push(2, 10'(10'h200 | i));
        wait_idle(120, "cnt_wait_idle");
        req = 1'b1;
        idx = 2'd2;
        step();
        chk("cnt_ch6", {27'd0, contador_out}, 32'd1);
        chk("cnt_vld", {31'd0, valid_contador}, 32'd1);
        idx = 2'd0;
        step();
        chk("cnt_ch4", {27'd0, contador_out}, 32'd0);
        req = 1'b0;
        step();
        chk("cnt_vld_off", {31'd0, valid_contador}, 32'd0);
`else
        req = 1'b1;
        idx = 2'd2;
        step();
        chk("nocnt_out", {27'd0, contador_out}, 32'd0);
        chk("nocnt_vld", {31'd0, valid_contador}, 32'd0);
        req = 1'b0;
`endif

        // reset while a word sits in HOLD: dropped, FIFO not rewound
        out_ready = 1'b0;
        push(0, 10'h0F0);
        wait_valid(10, "mid_wait_valid");
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {22'd0, out_data}, 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mid_rst_idle", {31'd0, IDLE}, 32'd1);
        chk("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
`ifdef EGRESS_CNT_EN
        req = 1'b1;
        idx = 2'd2;
        step();
        chk("mid_rst_cnt", {27'd0, contador_out}, 32'd0);
        req = 1'b0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
